// File: rtl/ex_stage_muldiv.sv
// rtl/ex_stage_muldiv.sv - execute stage with single-cycle ALU and iterative MUL/DIVU/REMU
module ex_stage_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            RegWrite_i,
  input  logic            MemWrite_i,
  input  logic            MemRead_i,
  input  logic            Mem2Reg_i,
  input  logic [XLEN-1:0] RSdata_i,
  input  logic [XLEN-1:0] RTdata_i,
  input  logic [XLEN-1:0] StoreData_i,
  input  logic [9:0]      funct_i,
  input  logic [4:0]      RDaddr_i,
  output logic [XLEN-1:0] ALUresult_o,
  output logic [XLEN-1:0] StoreData_o,
  output logic            RegWrite_o,
  output logic            MemWrite_o,
  output logic            MemRead_o,
  output logic            Mem2Reg_o,
  output logic [4:0]      RDaddr_o,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_q, b_q, acc_q;
  logic [1:0]      op_q;
  logic            rw_q, mw_q, mr_q, m2r_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] sd_q;

  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] alu_res;
  logic            is_muldiv;
  logic [1:0]      md_op;
  logic            start;
  logic            stall;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];

  // md_op: 00 MUL, 01 DIVU, 10 REMU
  always_comb begin
    alu_res   = '0;
    is_muldiv = 1'b0;
    md_op     = 2'b00;
    case (ALUOp_i)
      2'b00, 2'b11: alu_res = RSdata_i + RTdata_i;
      2'b01:        alu_res = RSdata_i - RTdata_i;
      default: begin
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  alu_res = RSdata_i + RTdata_i;
              3'b111:  alu_res = RSdata_i & RTdata_i;
              3'b110:  alu_res = RSdata_i | RTdata_i;
              3'b100:  alu_res = RSdata_i ^ RTdata_i;
              3'b001:  alu_res = RSdata_i << RTdata_i[4:0];
              default: alu_res = '0;
            endcase
          end
          7'b0100000: if (funct3 == 3'b000) alu_res = RSdata_i - RTdata_i;
          7'b0000001: begin
            case (funct3)
              3'b000:  begin is_muldiv = 1'b1; md_op = 2'b00; end
              3'b101:  begin is_muldiv = 1'b1; md_op = 2'b01; end
              3'b111:  begin is_muldiv = 1'b1; md_op = 2'b10; end
              default: is_muldiv = 1'b0;
            endcase
          end
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  assign start = valid_i & is_muldiv;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = BUSY;
          stall   = 1'b1;
        end
        BUSY: begin
          stall = 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_o = stall & ~rst_i;

  // MUL: acc += a when b[0]; a shifts left, b right.
  // DIV: a shifts the dividend out and the quotient in; acc is the partial remainder.
  logic [XLEN-1:0] mul_acc;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] rem_diff;
  logic            rem_ge;

  assign mul_acc  = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh   = {acc_q, a_q[XLEN-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
  assign rem_ge   = ~rem_diff[XLEN+1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      op_q  <= 2'b00;
      rw_q  <= 1'b0;
      mw_q  <= 1'b0;
      mr_q  <= 1'b0;
      m2r_q <= 1'b0;
      rd_q  <= '0;
      sd_q  <= '0;
    end else if (!flush_i && state_q == IDLE && start) begin
      cnt_q <= '0;
      a_q   <= RSdata_i;
      b_q   <= RTdata_i;
      acc_q <= '0;
      op_q  <= md_op;
      rw_q  <= RegWrite_i;
      mw_q  <= MemWrite_i;
      mr_q  <= MemRead_i;
      m2r_q <= Mem2Reg_i;
      rd_q  <= RDaddr_i;
      sd_q  <= StoreData_i;
    end else if (!flush_i && state_q == BUSY) begin
      cnt_q <= cnt_q + CW'(1);
      if (op_q == 2'b00) begin
        acc_q <= mul_acc;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else begin
        acc_q <= rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        a_q   <= {a_q[XLEN-2:0], rem_ge};
      end
    end
  end

  logic [XLEN-1:0] res_d, sd_d;
  logic            rw_d, mw_d, mr_d, m2r_d;
  logic [4:0]      rd_d;

  always_comb begin
    res_d = '0;
    sd_d  = '0;
    rw_d  = 1'b0;
    mw_d  = 1'b0;
    mr_d  = 1'b0;
    m2r_d = 1'b0;
    rd_d  = '0;
    if (!flush_i) begin
      if (state_q == IDLE && valid_i && !is_muldiv) begin
        res_d = alu_res;
        sd_d  = StoreData_i;
        rw_d  = RegWrite_i;
        mw_d  = MemWrite_i;
        mr_d  = MemRead_i;
        m2r_d = Mem2Reg_i;
        rd_d  = RDaddr_i;
      end else if (state_q == DONE) begin
        res_d = (op_q == 2'b01) ? a_q : acc_q;
        sd_d  = sd_q;
        rw_d  = rw_q;
        mw_d  = mw_q;
        mr_d  = mr_q;
        m2r_d = m2r_q;
        rd_d  = rd_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ALUresult_o <= '0;
      StoreData_o <= '0;
      RegWrite_o  <= 1'b0;
      MemWrite_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      Mem2Reg_o   <= 1'b0;
      RDaddr_o    <= '0;
    end else begin
      ALUresult_o <= res_d;
      StoreData_o <= sd_d;
      RegWrite_o  <= rw_d;
      MemWrite_o  <= mw_d;
      MemRead_o   <= mr_d;
      Mem2Reg_o   <= m2r_d;
      RDaddr_o    <= rd_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// tb/tb_ex_stage_muldiv.sv - directed self-checking bench for ex_stage_muldiv
module tb_ex_stage_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        flush_i;
  logic [1:0]  ALUOp_i;
  logic        RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i;
  logic [31:0] RSdata_i, RTdata_i, StoreData_i;
  logic [9:0]  funct_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] ALUresult_o, StoreData_o;
  logic        RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o;
  logic [4:0]  RDaddr_o;
  logic        stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage_muldiv #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i),
    .MemRead_i(MemRead_i), .Mem2Reg_i(Mem2Reg_i), .RSdata_i(RSdata_i),
    .RTdata_i(RTdata_i), .StoreData_i(StoreData_i), .funct_i(funct_i),
    .RDaddr_i(RDaddr_i), .ALUresult_o(ALUresult_o), .StoreData_o(StoreData_o),
    .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
    .Mem2Reg_o(Mem2Reg_o), .RDaddr_o(RDaddr_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [9:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic v, input logic [4:0] rd);
    valid_i = v; flush_i = 1'b0; ALUOp_i = op; funct_i = f;
    RSdata_i = a; RTdata_i = b; RDaddr_i = rd;
    RegWrite_i = 1'b1; MemWrite_i = 1'b0; MemRead_i = 1'b0; Mem2Reg_i = 1'b0;
    StoreData_i = 32'h5A5A_0000 ^ a;
  endtask

  task automatic alu_op(input string tag, input logic [1:0] op, input logic [9:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic v,
                        input logic [31:0] exp, input logic exp_rw);
    drive(op, f, a, b, v, 5'd7);
    #1;
    check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    tick();
    check({tag, "_res"}, ALUresult_o, exp);
    check({tag, "_rw"}, {31'd0, RegWrite_o}, {31'd0, exp_rw});
  endtask

  task automatic run_muldiv(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic bub;
    drive(2'b10, {7'b0000001, f3}, a, b, 1'b1, 5'd9);
    #1;
    n = 0;
    bub = 1'b1;
    while (stall_o && n < 100) begin
      tick();
      n++;
      if (RegWrite_o !== 1'b0 || ALUresult_o !== 32'd0) bub = 1'b0;
      #1;
    end
    check({tag, "_stall_cycles"}, n, 32'd33);
    check({tag, "_bubbles"}, {31'd0, bub}, 32'd1);
    tick();
    check({tag, "_res"}, ALUresult_o, exp);
    check({tag, "_rw"}, {31'd0, RegWrite_o}, 32'd1);
    check({tag, "_rd"}, {27'd0, RDaddr_o}, 32'd9);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(2'b10, {7'b0000001, 3'b000}, $urandom, $urandom, 1'b1, 5'd31);
    MemWrite_i = 1'b1; MemRead_i = 1'b1; Mem2Reg_i = 1'b1;
    tick();
    tick();
    check("rst_res", ALUresult_o, 32'd0);
    check("rst_sd", StoreData_o, 32'd0);
    check("rst_ctl", {28'd0, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o}, 32'd0);
    check("rst_rd", {27'd0, RDaddr_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    rst_i = 1'b0;
    valid_i = 1'b0;
    tick();

    drive(2'b10, {7'b0100000, 3'b000}, 32'd5, 32'd7, 1'b1, 5'd3);
    #1;
    check("sub_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("sub_res", ALUresult_o, 32'hFFFF_FFFE);
    check("sub_rw", {31'd0, RegWrite_o}, 32'd1);
    check("sub_rd", {27'd0, RDaddr_o}, 32'd3);

    alu_op("add00", 2'b00, 10'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 1'b1);
    alu_op("sub01", 2'b01, 10'd0, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    alu_op("addi", 2'b11, 10'h3FF, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 1'b1);
    alu_op("and", 2'b10, {7'b0, 3'b111}, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 1'b1);
    alu_op("or", 2'b10, {7'b0, 3'b110}, 32'hF000_0000, 32'h0000_000F, 1'b1, 32'hF000_000F, 1'b1);
    alu_op("xor", 2'b10, {7'b0, 3'b100}, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 1'b1);
    alu_op("sll", 2'b10, {7'b0, 3'b001}, 32'd1, 32'h23, 1'b1, 32'd8, 1'b1);
    alu_op("radd", 2'b10, {7'b0, 3'b000}, 32'd10, 32'd20, 1'b1, 32'd30, 1'b1);
    alu_op("mulh_unk", 2'b10, {7'b0000001, 3'b001}, 32'd6, 32'd7, 1'b1, 32'd0, 1'b1);
    alu_op("sub_unk", 2'b10, {7'b0100000, 3'b001}, 32'd6, 32'd7, 1'b1, 32'd0, 1'b1);
    alu_op("bubble", 2'b00, 10'd0, 32'd6, 32'd7, 1'b0, 32'd0, 1'b0);

    drive(2'b11, 10'd0, 32'h100, 32'h8, 1'b1, 5'd4);
    RegWrite_i = 1'b0; MemWrite_i = 1'b1; StoreData_i = 32'hCAFE_F00D;
    tick();
    check("sw_addr", ALUresult_o, 32'h108);
    check("sw_data", StoreData_o, 32'hCAFE_F00D);
    check("sw_ctl", {28'd0, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o}, 32'b0100);

    run_muldiv("mul", 3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    drive(2'b00, 10'd0, 32'd1, 32'd2, 1'b1, 5'd12);
    #1;
    check("b2b_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("b2b_res", ALUresult_o, 32'd3);
    check("b2b_rd", {27'd0, RDaddr_o}, 32'd12);

    run_muldiv("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    run_muldiv("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    run_muldiv("divu0", 3'b101, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
    run_muldiv("remu0", 3'b111, 32'h1234, 32'd0, 32'h1234);

    drive(2'b10, {7'b0000001, 3'b000}, 32'd7, 32'd9, 1'b1, 5'd9);
    tick();
    repeat (10) tick();
    check("flush_pre_stall", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("flush_res", ALUresult_o, 32'd0);
    check("flush_rw", {31'd0, RegWrite_o}, 32'd0);
    drive(2'b00, 10'd0, 32'd10, 32'd20, 1'b1, 5'd5);
    #1;
    check("post_flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("post_flush_res", ALUresult_o, 32'd30);
    check("post_flush_rw", {31'd0, RegWrite_o}, 32'd1);

    drive(2'b10, {7'b0000001, 3'b000}, 32'd7, 32'd9, 1'b1, 5'd9);
    tick();
    repeat (20) tick();
    rst_i = 1'b1;
    #1;
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    check("midrst_res", ALUresult_o, 32'd0);
    check("midrst_rw", {31'd0, RegWrite_o}, 32'd0);
    run_muldiv("mul34", 3'b000, 32'd3, 32'd4, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
